// File: rtl/mm_host_ctrl.sv
// Host-side launcher for the matrix-multiply DUT: loads input/weight SRAMs, starts the DUT, drains results.
// Optional watchdog with sticky timeout_err output is enabled by defining MM_HOST_TIMEOUT_EN.
module mm_host_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_in_words,
  input  logic [ADDR_W-1:0] cmd_wt_words,
  input  logic [ADDR_W-1:0] cmd_res_words,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              host_sram_input_write_enable,
  output logic [ADDR_W-1:0] host_sram_input_write_address,
  output logic [DATA_W-1:0] host_sram_input_write_data,
  output logic              host_sram_weight_write_enable,
  output logic [ADDR_W-1:0] host_sram_weight_write_address,
  output logic [DATA_W-1:0] host_sram_weight_write_data,
  output logic [ADDR_W-1:0] host_sram_result_read_address,
  input  logic [DATA_W-1:0] sram_host_result_read_data,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic              busy,
`ifdef MM_HOST_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_IN, LOAD_WT, LAUNCH, WAIT_ACK, WAIT_DONE, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] in_words, wt_words, res_words;
  logic [ADDR_W-1:0] ptr, rd_ptr, pop_cnt;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wr_idx, fifo_rd_idx;
  logic [1:0]        fifo_count;
  logic              inflight;
  logic              dut_valid_q;

  logic              cmd_fire, ld_fire, ld_last, push, pop, last_pop, rd_issue;
  logic [2:0]        occupancy;

`ifdef MM_HOST_TIMEOUT_EN
  localparam logic [23:0] WD_MAX = '1;
  logic [23:0] wd;
  logic        waiting;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    ld_ready  = (state == LOAD_IN) || (state == LOAD_WT);
    cmd_fire  = cmd_valid && cmd_ready;
    ld_fire   = ld_valid && ld_ready;
    ld_last   = (state == LOAD_IN) ? (ptr == in_words - ADDR_W'(1))
                                   : (ptr == wt_words - ADDR_W'(1));

    host_sram_input_write_enable   = (state == LOAD_IN) && ld_valid;
    host_sram_input_write_address  = ptr;
    host_sram_input_write_data     = ld_data;
    host_sram_weight_write_enable  = (state == LOAD_WT) && ld_valid;
    host_sram_weight_write_address = ptr;
    host_sram_weight_write_data    = ld_data;

    dut_valid = dut_valid_q;

    res_valid = (fifo_count != 2'd0);
    res_data  = fifo_mem[fifo_rd_idx];
    res_last  = res_valid && (pop_cnt == res_words - ADDR_W'(1));
    pop       = res_valid && res_ready;
    push      = inflight;
    last_pop  = pop && (pop_cnt == res_words - ADDR_W'(1));

    // Counting the same-cycle pop keeps one read issued per cycle while the consumer keeps up.
    occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    rd_issue  = (state == DRAIN) && (rd_ptr < res_words) && (occupancy < 3'd2);
    host_sram_result_read_address = rd_ptr;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (cmd_fire) begin
          if (cmd_in_words != '0)      state_nx = LOAD_IN;
          else if (cmd_wt_words != '0) state_nx = LOAD_WT;
          else                         state_nx = LAUNCH;
        end
      LOAD_IN:
        if (ld_fire && ld_last) state_nx = (wt_words != '0) ? LOAD_WT : LAUNCH;
      LOAD_WT:
        if (ld_fire && ld_last) state_nx = LAUNCH;
      LAUNCH:
        if (dut_ready) state_nx = WAIT_ACK;
      WAIT_ACK:
        if (!dut_ready) state_nx = WAIT_DONE;
      WAIT_DONE:
        if (dut_ready) state_nx = (res_words == '0) ? DONE : DRAIN;
      DRAIN:
        if (last_pop) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
`ifdef MM_HOST_TIMEOUT_EN
    waiting = (state == WAIT_ACK) || (state == WAIT_DONE);
    if (waiting && (wd == WD_MAX)) state_nx = DONE;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_words    <= '0;
      wt_words    <= '0;
      res_words   <= '0;
      ptr         <= '0;
      rd_ptr      <= '0;
      pop_cnt     <= '0;
      fifo_wr_idx <= 1'b0;
      fifo_rd_idx <= 1'b0;
      fifo_count  <= 2'd0;
      inflight    <= 1'b0;
      dut_valid_q <= 1'b0;
    end else begin
      dut_valid_q <= (state == LAUNCH) && dut_ready;
      inflight    <= rd_issue;
      if (cmd_fire) begin
        in_words    <= cmd_in_words;
        wt_words    <= cmd_wt_words;
        res_words   <= cmd_res_words;
        ptr         <= '0;
        rd_ptr      <= '0;
        pop_cnt     <= '0;
        fifo_wr_idx <= 1'b0;
        fifo_rd_idx <= 1'b0;
        fifo_count  <= 2'd0;
      end else begin
        if (ld_fire)  ptr <= ld_last ? '0 : ptr + ADDR_W'(1);
        if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
        if (push)     fifo_wr_idx <= ~fifo_wr_idx;
        if (pop) begin
          fifo_rd_idx <= ~fifo_rd_idx;
          pop_cnt     <= pop_cnt + ADDR_W'(1);
        end
        fifo_count <= fifo_count + 2'(push) - 2'(pop);
      end
    end
  end

  // NOTE: FIFO storage is not reset; fifo_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_idx] <= sram_host_result_read_data;
  end

`ifdef MM_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (cmd_fire) timeout_err <= 1'b0;
      if (waiting) begin
        wd <= wd + 24'd1;
        if (wd == WD_MAX) timeout_err <= 1'b1;
      end else begin
        wd <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/mm_host_ctrl.md
Name: mm_host_ctrl

Overview:
- Host-side launcher for the matrix-multiply DUT; drives the opposite end of the DUT's SRAM and dut_valid/dut_ready handshake.
- Writes input and weight matrices into the input/weight SRAMs from a load stream.
- Launches the DUT with dut_valid and waits for completion on dut_ready.
- Drains result SRAM words to a backpressured output stream.

Parameters:
- ADDR_W, 16, SRAM address width (matches SRAM_ADDR_RANGE)
- DATA_W, 32, SRAM data width (matches SRAM_DATA_RANGE)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  start command valid
- cmd_ready  out  1  high only in IDLE
- cmd_in_words  in  ADDR_W  words to load into input SRAM, header included
- cmd_wt_words  in  ADDR_W  words to load into weight SRAM, header included
- cmd_res_words  in  ADDR_W  result words to drain
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted
- ld_data  in  DATA_W  load word
- host_sram_input_write_enable / _address / _data  out  1/ADDR_W/DATA_W  input SRAM write port
- host_sram_weight_write_enable / _address / _data  out  1/ADDR_W/DATA_W  weight SRAM write port
- host_sram_result_read_address  out  ADDR_W  result SRAM read address
- sram_host_result_read_data  in  DATA_W  result SRAM read data, 1-cycle latency
- dut_valid  out  1  DUT start request
- dut_ready  in  1  DUT idle/done
- res_valid  out  1  result word valid
- res_ready  in  1  result consumer ready
- res_data  out  DATA_W  result word
- res_last  out  1  marks final result word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of job

Behaviour:
- Reset (async, active-high): state=IDLE, all counters 0, FIFO empty.
  - Output values under reset: dut_valid=0, write enables=0, res_valid=0, done=0, busy=0.
  - cmd_ready=1 out of reset (combinational, state==IDLE).
  - Reset mid-job aborts immediately; no further SRAM writes.
- States: IDLE, LOAD_IN, LOAD_WT, LAUNCH, WAIT_ACK, WAIT_DONE, DRAIN, DONE.
- IDLE:
  - On cmd_valid&&cmd_ready, latch the three counts and clear ptr.
  - Next state is the first of LOAD_IN / LOAD_WT / LAUNCH whose count is nonzero, taken in that order.
  - cmd_valid in any other state is ignored.
- LOAD_IN / LOAD_WT:
  - ld_ready=1.
  - write_enable = ld_valid combinationally; address = ptr; data = ld_data.
  - ptr increments per accepted word.
  - On the accept of the last word (ptr==count-1): clear ptr and advance (LOAD_IN→LOAD_WT, or LAUNCH if wt count 0).
  - Input words always at input SRAM addresses 0..in_words-1; weight words at weight SRAM addresses 0..wt_words-1.
  - Never both write enables in one cycle.
- LAUNCH:
  - If dut_ready==1, assert registered dut_valid for exactly one cycle, then go to WAIT_ACK.
  - Otherwise hold, dut_valid=0.
- WAIT_ACK: wait for dut_ready==0.
- WAIT_DONE: wait for dut_ready==1; then DRAIN, or DONE if res_words==0.
- DRAIN:
  - Issue read address rd_ptr when rd_ptr<res_words and fifo_count+inflight<2.
  - Returned data is pushed into a 2-entry FIFO one cycle later.
  - res_valid = FIFO non-empty; pop on res_valid&&res_ready.
  - res_last=1 on popped word index res_words-1.
  - Full throughput: 1 word/cycle with res_ready held high; no word lost or duplicated under any res_ready pattern.
  - After the last pop, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Counters are ADDR_W wide; count 0 means skip that phase; maximum count 65535, with no wrap beyond count-1.

Optional Feature:
- Macro: MM_HOST_TIMEOUT_EN.
- Enabled:
  - Adds output timeout_err (1 bit, sticky until the next accepted command).
  - 24-bit watchdog counts cycles in WAIT_ACK+WAIT_DONE; reaching 2^24-1 sets timeout_err and jumps to DONE.
  - done still pulses; no drain occurs.
- Disabled: no port, no counter; waits indefinitely.

Test Plan:
- Cmd in=5, wt=3, res=4 with ld_valid always 1:
  - Input writes at addresses 0..4, then weight writes at 0..2, in consecutive cycles.
  - Then a single-cycle dut_valid, then 4 res words carrying SRAM data of addresses 0..3; res_last on the 4th; done pulse.
- Random ld_valid gaps and random res_ready (50%): every word is written exactly once in order; res_data sequence equals result SRAM contents 0..N-1 with no drops or duplicates.
- dut_ready held 0 for 10 cycles in LAUNCH: dut_valid stays 0; it pulses once in the cycle after dut_ready rises; busy=1 throughout.
- Cmd with in=0, wt=0, res=0: goes directly to LAUNCH; after the handshake completes, done pulses with no SRAM writes and no res_valid.
- Reset asserted mid-LOAD_IN (after 2 words): outputs go to 0 asynchronously and cmd_ready=1 after release; a new cmd restarts the write address at 0.
- With MM_HOST_TIMEOUT_EN and dut_ready stuck 1 after launch: timeout_err=1 after 2^24-1 cycles, done pulses, returns to IDLE.
